// File: rtl/m_sipo_pkg.sv
// Shared types for the SIPO frame receiver: FSM state encoding and counter sizing.
package m_sipo_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/m_sipo_shifter.sv
// Parametric serial-in/parallel-out register: first bit in ends up in Q[WIDTH-1].
module m_sipo_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CLR,
  input  logic             SI,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Clear wins over shift so a restart drops any bit strobed on the same cycle.
  always_comb begin
    q_d = q_q;
    if (CLR)     q_d = '0;
    else if (EN) q_d = {q_q[WIDTH-2:0], SI};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q_q <= '0;
    else        q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/m_sipo_rx_ctrl.sv
// SIPO frame controller: FSM, bit counter, 1-entry output buffer with valid/ready, overrun flag.
// Optional parity bit per frame when M_SIPO_PARITY_EN is defined.
module m_sipo_rx_ctrl
  import m_sipo_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PAR_ODD = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SI,
  input  logic             SI_VALID,
  output logic [WIDTH-1:0] PO,
  output logic             PO_VALID,
  input  logic             PO_READY,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             PAR_ERR
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] po_q;
  logic             po_valid_q, overrun_q, par_err_q;
  logic [WIDTH-1:0] shift_q;
  logic             shift_en, done, load, perr_d;
  logic [WIDTH-1:0] word_d;

  assign shift_en = SI_VALID && (state_q == SHIFT);

  m_sipo_shifter #(.WIDTH(WIDTH)) u_shifter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (shift_en),
    .CLR   (START),
    .SI    (SI),
    .Q     (shift_q)
  );

`ifdef M_SIPO_PARITY_EN
  always_comb begin
    done   = SI_VALID && !START && (state_q == PAR);
    word_d = shift_q;
    perr_d = ((^shift_q) ^ SI) != PAR_ODD[0];
  end
`else
  // Word is taken from the shifter's next value so PO loads on the edge that samples the last bit.
  always_comb begin
    done   = shift_en && !START && (cnt_q == LAST);
    word_d = WIDTH'({shift_q, SI});
    perr_d = 1'b0;
  end
`endif

  assign load = done && (!po_valid_q || PO_READY);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      overrun_q <= done && !load;
      if (load) begin
        po_q       <= word_d;
        po_valid_q <= 1'b1;
        par_err_q  <= perr_d;
      end else if (po_valid_q && PO_READY) begin
        po_valid_q <= 1'b0;
      end

      if (START) begin
        state_q <= SHIFT;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          SHIFT: if (SI_VALID) begin
            if (cnt_q == LAST) begin
              cnt_q <= '0;
`ifdef M_SIPO_PARITY_EN
              state_q <= PAR;
`else
              state_q <= IDLE;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          PAR:     if (SI_VALID) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign PO       = po_q;
  assign PO_VALID = po_valid_q;
  assign BUSY     = (state_q != IDLE);
  assign OVERRUN  = overrun_q;
  assign PAR_ERR  = par_err_q;

endmodule

// File: tb/tb_m_sipo_rx_ctrl.sv
// Directed self-checking bench for m_sipo_rx_ctrl (WIDTH=4, default build without parity).
module tb_m_sipo_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       SI = 1'b0;
  logic       SI_VALID = 1'b0;
  logic       PO_READY = 1'b0;
  logic [3:0] PO;
  logic       PO_VALID, BUSY, OVERRUN, PAR_ERR;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  m_sipo_rx_ctrl #(.WIDTH(4), .PAR_ODD(0)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .SI       (SI),
    .SI_VALID (SI_VALID),
    .PO       (PO),
    .PO_VALID (PO_VALID),
    .PO_READY (PO_READY),
    .BUSY     (BUSY),
    .OVERRUN  (OVERRUN),
    .PAR_ERR  (PAR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int unsigned gap);
    SI = b;
    SI_VALID = 1'b1;
    step();
    SI_VALID = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i], 0);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    step();
    step();
    n_total++; if (PO !== 4'h0) $display("FAIL reset_po: got %h want 0", PO); else n_pass++;
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", PO_VALID); else n_pass++;
    n_total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
    n_total++; if (OVERRUN !== 1'b0) $display("FAIL reset_overrun: got %b want 0", OVERRUN); else n_pass++;
    n_total++; if (PAR_ERR !== 1'b0) $display("FAIL reset_parerr: got %b want 0", PAR_ERR); else n_pass++;
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_basic();
    PO_READY = 1'b1;
    start_frame();
    n_total++; if (BUSY !== 1'b1) $display("FAIL basic_busy: got %b want 1", BUSY); else n_pass++;
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", PO_VALID); else n_pass++;
    send_bit(1'b1, 0);
    n_total++; if (PO_VALID !== 1'b1) $display("FAIL basic_valid: got %b want 1", PO_VALID); else n_pass++;
    n_total++; if (PO !== 4'b1011) $display("FAIL basic_po: got %b want 1011", PO); else n_pass++;
    n_total++; if (BUSY !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", BUSY); else n_pass++;
    step();
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL basic_valid_fall: got %b want 0", PO_VALID); else n_pass++;
  endtask

  task automatic test_gapped();
    PO_READY = 1'b1;
    // A strobe on the START cycle must be ignored.
    SI = 1'b0; SI_VALID = 1'b1;
    start_frame();
    SI_VALID = 1'b0;
    send_bit(1'b1, 3);
    n_total++; if (BUSY !== 1'b1) $display("FAIL gap_busy1: got %b want 1", BUSY); else n_pass++;
    send_bit(1'b0, 0);
    send_bit(1'b1, 2);
    n_total++; if (BUSY !== 1'b1) $display("FAIL gap_busy3: got %b want 1", BUSY); else n_pass++;
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL gap_valid_mid: got %b want 0", PO_VALID); else n_pass++;
    send_bit(1'b1, 0);
    n_total++; if (PO !== 4'b1011) $display("FAIL gap_po: got %b want 1011", PO); else n_pass++;
    n_total++; if (PO_VALID !== 1'b1) $display("FAIL gap_valid: got %b want 1", PO_VALID); else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    PO_READY = 1'b0;
    start_frame(); send_word(4'hA);
    n_total++; if (PO !== 4'hA) $display("FAIL bp_po_a: got %h want a", PO); else n_pass++;
    start_frame();
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    n_total++; if (PO !== 4'hA) $display("FAIL bp_po_hold: got %h want a", PO); else n_pass++;
    send_bit(1'b1, 0);
    n_total++; if (OVERRUN !== 1'b1) $display("FAIL bp_overrun: got %b want 1", OVERRUN); else n_pass++;
    n_total++; if (PO !== 4'hA) $display("FAIL bp_po_kept: got %h want a", PO); else n_pass++;
    n_total++; if (PO_VALID !== 1'b1) $display("FAIL bp_valid: got %b want 1", PO_VALID); else n_pass++;
    step();
    n_total++; if (OVERRUN !== 1'b0) $display("FAIL bp_overrun_pulse: got %b want 0", OVERRUN); else n_pass++;
    PO_READY = 1'b1;
    step();
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL bp_consumed: got %b want 0", PO_VALID); else n_pass++;
    PO_READY = 1'b0;
  endtask

  task automatic test_same_cycle();
    PO_READY = 1'b0;
    start_frame(); send_word(4'hA);
    start_frame();
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    PO_READY = 1'b1;
    send_bit(1'b1, 0);
    n_total++; if (PO !== 4'h5) $display("FAIL sc_po: got %h want 5", PO); else n_pass++;
    n_total++; if (PO_VALID !== 1'b1) $display("FAIL sc_valid: got %b want 1", PO_VALID); else n_pass++;
    n_total++; if (OVERRUN !== 1'b0) $display("FAIL sc_overrun: got %b want 0", OVERRUN); else n_pass++;
    step();
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL sc_valid_fall: got %b want 0", PO_VALID); else n_pass++;
    PO_READY = 1'b0;
  endtask

  task automatic test_restart_reset();
    PO_READY = 1'b1;
    start_frame();
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    start_frame();
    n_total++; if (BUSY !== 1'b1) $display("FAIL rs_busy: got %b want 1", BUSY); else n_pass++;
    send_word(4'b0110);
    n_total++; if (PO !== 4'h6) $display("FAIL rs_po: got %h want 6", PO); else n_pass++;
    step();
    // Pending word plus a partial frame, then asynchronous reset between edges.
    PO_READY = 1'b0;
    start_frame(); send_word(4'hF);
    start_frame(); send_bit(1'b1, 0); send_bit(1'b0, 0);
    #2 RST_N = 1'b0;
    #1;
    n_total++; if (PO !== 4'h0) $display("FAIL arst_po: got %h want 0", PO); else n_pass++;
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL arst_valid: got %b want 0", PO_VALID); else n_pass++;
    n_total++; if (BUSY !== 1'b0) $display("FAIL arst_busy: got %b want 0", BUSY); else n_pass++;
    step();
    RST_N = 1'b1;
    step();
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    n_total++; if (PO_VALID !== 1'b0) $display("FAIL idle_ignore_valid: got %b want 0", PO_VALID); else n_pass++;
    n_total++; if (BUSY !== 1'b0) $display("FAIL idle_ignore_busy: got %b want 0", BUSY); else n_pass++;
  endtask

  task automatic test_back_to_back();
    PO_READY = 1'b1;
    start_frame(); send_word(4'h9);
    START = 1'b1;
    n_total++; if (PO !== 4'h9) $display("FAIL b2b_po1: got %h want 9", PO); else n_pass++;
    step();
    START = 1'b0;
    send_word(4'h3);
    n_total++; if (PO !== 4'h3) $display("FAIL b2b_po2: got %h want 3", PO); else n_pass++;
    n_total++; if (PO_VALID !== 1'b1) $display("FAIL b2b_valid2: got %b want 1", PO_VALID); else n_pass++;
    n_total++; if (PAR_ERR !== 1'b0) $display("FAIL b2b_parerr: got %b want 0", PAR_ERR); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_same_cycle();
    test_restart_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
